// File: rtl/colr_pkg.sv
// colr_pkg: shared types and constants for the colour-depth adapter.
//   mode_e    - conversion modes (pad/truncate, replicate/round, dither, temporal dither)
//   timing_t  - display timing bundle carried alongside each pixel
//   DITHER_B  - 2x2 ordered-dither matrix, indexed DITHER_B[y][x]
package colr_pkg;

    typedef enum logic [1:0] {
        MODE_TRUNC_PAD = 2'd0,
        MODE_ROUND_REP = 2'd1,
        MODE_DITHER    = 2'd2,
        MODE_TDITHER   = 2'd3
    } mode_e;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic de;
    } timing_t;

    // Rows packed high-to-low: row 1 = {B[1][1], B[1][0]} = {1, 3},
    // row 0 = {B[0][1], B[0][0]} = {2, 0}.
    localparam logic [1:0][1:0][1:0] DITHER_B = {{2'd1, 2'd3}, {2'd2, 2'd0}};

    function automatic logic [1:0] dither_b(input logic y, input logic x);
        return DITHER_B[y][x];
    endfunction

endpackage

// File: rtl/colr_chan_conv.sv
// colr_chan_conv: combinational single-channel depth conversion.
//   value  [BPC_IN]  - input channel value
//   offset [BPC_IN]  - dither offset for this cycle (used by dither modes on reduction)
//   mode             - conversion mode
//   result [BPC_OUT] - converted channel value
module colr_chan_conv
    import colr_pkg::*;
#(
    parameter int BPC_IN  = 5,
    parameter int BPC_OUT = 8
)(
    input  logic [BPC_IN-1:0]  value,
    input  logic [BPC_IN-1:0]  offset,
    input  mode_e              mode,
    output logic [BPC_OUT-1:0] result
);

    generate
        if (BPC_OUT > BPC_IN) begin : g_expand
            // Replicate the input cyclically and keep the top BPC_OUT bits,
            // e.g. 5->8 gives {d, d[4:2]}.
            localparam int REPS = (BPC_OUT + BPC_IN - 1) / BPC_IN;
            logic [REPS*BPC_IN-1:0] rep;
            logic                   unused_off;

            assign rep        = {REPS{value}};
            assign unused_off = ^offset;

            always_comb begin
                if (mode == MODE_TRUNC_PAD)
                    result = {value, {(BPC_OUT-BPC_IN){1'b0}}};
                else
                    result = rep[REPS*BPC_IN-1 -: BPC_OUT];
            end
        end else if (BPC_OUT == BPC_IN) begin : g_pass
            logic unused_in;

            assign unused_in = ^{offset, mode};
            assign result    = value;
        end else begin : g_reduce
            localparam int D = BPC_IN - BPC_OUT;
            logic [BPC_IN-1:0] add;
            logic [BPC_IN:0]   sum;
            logic [BPC_IN-1:0] sat;
            logic              unused_lo;

            always_comb begin
                case (mode)
                    MODE_TRUNC_PAD: add = '0;
                    MODE_ROUND_REP: add = BPC_IN'(1) << (D - 1);
                    default:        add = offset;
                endcase
            end

            // One extra bit catches the carry; saturate rather than wrap.
            assign sum       = {1'b0, value} + {1'b0, add};
            assign sat       = sum[BPC_IN] ? '1 : sum[BPC_IN-1:0];
            assign result    = sat[BPC_IN-1 -: BPC_OUT];
            assign unused_lo = ^sat[D-1:0];
        end
    endgenerate

endmodule

// File: rtl/colr_adapt.sv
// colr_adapt: colour-depth adapter with optional ordered dithering.
//   clk_pix, rst_pix                  - pixel clock, async active-high reset
//   mode_req                          - requested mode, adopted on vsync rising edge
//   disp_hsync/disp_vsync/disp_de     - input timing
//   din  [CHANNELS*BPC_IN]            - packed colour, channel 0 in LSBs
//   out_hsync/out_vsync/out_de, dout  - timing and colour, 2 cycles later
//   mode                              - mode currently in effect
module colr_adapt
    import colr_pkg::*;
#(
    parameter int         BPC_IN    = 5,
    parameter int         BPC_OUT   = 8,
    parameter int         CHANNELS  = 3,
    parameter logic [1:0] MODE_INIT = 2'd0
)(
    input  logic                         clk_pix,
    input  logic                         rst_pix,
    input  logic [1:0]                   mode_req,
    input  logic                         disp_hsync,
    input  logic                         disp_vsync,
    input  logic                         disp_de,
    input  logic [CHANNELS*BPC_IN-1:0]   din,
    output logic                         out_hsync,
    output logic                         out_vsync,
    output logic                         out_de,
    output logic [CHANNELS*BPC_OUT-1:0]  dout,
    output logic [1:0]                   mode
);

    localparam int D      = (BPC_IN > BPC_OUT) ? BPC_IN - BPC_OUT : 0;
    localparam int OFFW   = BPC_IN + 2;
    localparam int STAGES = 2;

    // Position / parity tracking
    logic  de_d, vs_d;
    logic  xpar, ypar, fpar;
    mode_e mode_q;
    logic  vs_rise, de_fall;

    assign vs_rise = disp_vsync & ~vs_d;
    assign de_fall = de_d & ~disp_de;

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            de_d   <= 1'b0;
            vs_d   <= 1'b0;
            xpar   <= 1'b0;
            ypar   <= 1'b0;
            fpar   <= 1'b0;
            mode_q <= mode_e'(MODE_INIT);
        end else begin
            de_d <= disp_de;
            vs_d <= disp_vsync;
            xpar <= disp_de ? ~xpar : 1'b0;
            if (disp_vsync)
                ypar <= 1'b0;
            else if (de_fall)
                ypar <= ~ypar;
            // New mode applies to the pixel after the edge; the pixel sampled
            // on the edge itself still enters the pipe with the old mode.
            if (vs_rise) begin
                fpar   <= ~fpar;
                mode_q <= mode_e'(mode_req);
            end
        end
    end

    assign mode = mode_q;

    // Dither offset for the current pixel, shared by all channels
    logic             bx, by, tflip;
    logic [1:0]       b_sel;
    logic [OFFW-1:0]  off_wide;
    logic [BPC_IN-1:0] off_cur;
    logic             unused_off;

    assign tflip      = (mode_q == MODE_TDITHER) & fpar;
    assign bx         = xpar ^ tflip;
    assign by         = ypar ^ tflip;
    assign b_sel      = dither_b(by, bx);
    assign off_wide   = (OFFW'(b_sel) << D) >> 2;
    assign off_cur    = off_wide[BPC_IN-1:0];
    assign unused_off = ^off_wide[OFFW-1:BPC_IN];

    // Pipeline: stage 1 captures pixel + offset + mode, stage 2 holds the result
    timing_t                       tim_in;
    timing_t [STAGES:1]            tim_pipe;
    logic [CHANNELS*BPC_IN-1:0]    s1_din;
    logic [BPC_IN-1:0]             s1_off;
    mode_e                         s1_mode;
    logic [CHANNELS*BPC_OUT-1:0]   conv_out;

    assign tim_in = '{hsync: disp_hsync, vsync: disp_vsync, de: disp_de};

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            tim_pipe <= '0;
            s1_din   <= '0;
            s1_off   <= '0;
            s1_mode  <= MODE_TRUNC_PAD;
            dout     <= '0;
        end else begin
            tim_pipe <= {tim_pipe[STAGES-1:1], tim_in};
            s1_din   <= din;
            s1_off   <= off_cur;
            s1_mode  <= mode_q;
            dout     <= conv_out;
        end
    end

    genvar c;
    generate
        for (c = 0; c < CHANNELS; c++) begin : g_chan
            colr_chan_conv #(
                .BPC_IN  (BPC_IN),
                .BPC_OUT (BPC_OUT)
            ) u_conv (
                .value  (s1_din[c*BPC_IN +: BPC_IN]),
                .offset (s1_off),
                .mode   (s1_mode),
                .result (conv_out[c*BPC_OUT +: BPC_OUT])
            );
        end
    endgenerate

    assign out_hsync = tim_pipe[STAGES].hsync;
    assign out_vsync = tim_pipe[STAGES].vsync;
    assign out_de    = tim_pipe[STAGES].de;

endmodule

// File: tb/tb_colr_adapt.sv
// tb_colr_adapt: randomized + directed check of colr_adapt against a
// count-based reference model. Two instances: 5->8 expansion (MODE_INIT 0)
// and 8->5 reduction (MODE_INIT 2), sharing timing and mode_req.
module tb_colr_adapt;

    localparam int CH = 3;
    localparam int XI = 5, XO = 8;
    localparam int RI = 8, RO = 5;
    localparam int INIT_X = 0, INIT_R = 2;

    logic              clk_pix = 1'b0;
    logic              rst_pix;
    logic [1:0]        mode_req;
    logic              hs, vs, de;
    logic [CH*XI-1:0]  din_x;
    logic [CH*XO-1:0]  dout_x;
    logic [CH*RI-1:0]  din_r;
    logic [CH*RO-1:0]  dout_r;
    logic              ohs_x, ovs_x, ode_x, ohs_r, ovs_r, ode_r;
    logic [1:0]        mode_x, mode_r;

    always #5 clk_pix = ~clk_pix;

    colr_adapt #(.BPC_IN(XI), .BPC_OUT(XO), .CHANNELS(CH), .MODE_INIT(2'(INIT_X))) u_dut_x (
        .clk_pix(clk_pix), .rst_pix(rst_pix), .mode_req(mode_req),
        .disp_hsync(hs), .disp_vsync(vs), .disp_de(de), .din(din_x),
        .out_hsync(ohs_x), .out_vsync(ovs_x), .out_de(ode_x), .dout(dout_x), .mode(mode_x));

    colr_adapt #(.BPC_IN(RI), .BPC_OUT(RO), .CHANNELS(CH), .MODE_INIT(2'(INIT_R))) u_dut_r (
        .clk_pix(clk_pix), .rst_pix(rst_pix), .mode_req(mode_req),
        .disp_hsync(hs), .disp_vsync(vs), .disp_de(de), .din(din_r),
        .out_hsync(ohs_r), .out_vsync(ovs_r), .out_de(ode_r), .dout(dout_r), .mode(mode_r));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s obs=%0d exp=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int dx;
        int dr;
        int tim;
    } exp_t;

    exp_t q[$];
    int   bm[2][2] = '{'{0, 2}, '{3, 1}};
    int   mx, mr;          // mode in effect
    int   xcnt;            // consecutive active cycles before this one
    int   lines;           // active-line ends since vsync
    int   frames;          // vsync rising edges since reset
    bit   pde, pvs;

    function automatic int ref_conv(int v, int bin, int bout, int m, int bv);
        int d, a, s, r;
        if (bout > bin) begin
            if (m == 0) return v << (bout - bin);
            r = 0;
            for (int k = 0; k < bout; k++)
                r = (r << 1) | ((v >> (bin - 1 - (k % bin))) & 1);
            return r;
        end
        if (bout == bin) return v;
        d = bin - bout;
        a = (m == 0) ? 0 : (m == 1) ? (1 << (d - 1)) : ((bv << d) >> 2);
        s = v + a;
        if (s > (1 << bin) - 1) s = (1 << bin) - 1;
        return s >> d;
    endfunction

    function automatic int dith(int m, int x, int y, int f);
        if (m == 3) return bm[y ^ f][x ^ f];
        return bm[y][x];
    endfunction

    task automatic reset_model();
        mx = INIT_X; mr = INIT_R;
        xcnt = 0; lines = 0; frames = 0;
        pde = 0; pvs = 0;
        q.delete();
    endtask

    task automatic step();
        exp_t e, o;
        int xb, yb, fb, bvx, bvr;
        xb = xcnt & 1; yb = lines & 1; fb = frames & 1;
        bvx = dith(mx, xb, yb, fb);
        bvr = dith(mr, xb, yb, fb);
        e.dx = 0; e.dr = 0;
        for (int c = 0; c < CH; c++) begin
            e.dx |= ref_conv((int'(din_x) >> (c*XI)) & ((1 << XI) - 1), XI, XO, mx, bvx) << (c*XO);
            e.dr |= ref_conv((int'(din_r) >> (c*RI)) & ((1 << RI) - 1), RI, RO, mr, bvr) << (c*RO);
        end
        e.tim = {29'd0, hs, vs, de};
        q.push_back(e);
        @(posedge clk_pix); #1;
        if (vs && !pvs) begin
            frames++;
            mx = int'(mode_req);
            mr = int'(mode_req);
        end
        if (vs) lines = 0;
        else if (pde && !de) lines++;
        xcnt = de ? xcnt + 1 : 0;
        pde = de; pvs = vs;
        if (q.size() == 2) begin
            o = q.pop_front();
            chk("dout_x", int'(dout_x), o.dx);
            chk("dout_r", int'(dout_r), o.dr);
            chk("tim_x", int'({ohs_x, ovs_x, ode_x}), o.tim);
            chk("tim_r", int'({ohs_r, ovs_r, ode_r}), o.tim);
        end else begin
            chk("fill_x", int'(dout_x), 0);
            chk("fill_r", int'({ohs_r, ovs_r, ode_r}), 0);
        end
        chk("mode_x", int'(mode_x), mx);
        chk("mode_r", int'(mode_r), mr);
    endtask

    task automatic randin();
        din_x = (CH*XI)'($urandom);
        din_r = (CH*RI)'($urandom);
    endtask

    task automatic frame(input int nl, input int np, input bit rnd, input int mid_mode);
        for (int i = 0; i < 2; i++) begin
            hs = 0; vs = 1; de = 0;
            if (rnd) randin();
            step();
        end
        for (int l = 0; l < nl; l++) begin
            if (l == 1 && mid_mode >= 0) mode_req = 2'(mid_mode);
            hs = 1; vs = 0; de = 0; step();
            hs = 0; step(); step();
            for (int p = 0; p < np; p++) begin
                de = 1;
                if (rnd) randin();
                step();
            end
            de = 0; step();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_dx"}, int'(dout_x), 0);
        chk({tag, "_dr"}, int'(dout_r), 0);
        chk({tag, "_tx"}, int'({ohs_x, ovs_x, ode_x}), 0);
        chk({tag, "_tr"}, int'({ohs_r, ovs_r, ode_r}), 0);
        chk({tag, "_mx"}, int'(mode_x), INIT_X);
        chk({tag, "_mr"}, int'(mode_r), INIT_R);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_pix = 1; mode_req = 0; hs = 0; vs = 0; de = 0;
        din_x = '1; din_r = '1;
        #1;
        check_reset_outputs("rst0");
        repeat (2) @(posedge clk_pix);
        #1;
        rst_pix = 0;
        reset_model();

        // Expansion 22 -> 176 / 181, reduction 181 -> 22 / 23, 255 -> 31
        din_x = {CH{5'd22}};
        din_r = {CH{8'd181}};
        mode_req = 0; frame(2, 4, 0, -1);
        mode_req = 1; frame(2, 4, 0, -1);
        din_r = {CH{8'd255}};
        frame(1, 3, 0, -1);

        // Spatial and spatio-temporal dither on constant 180
        din_r = {CH{8'd180}};
        mode_req = 2; frame(2, 2, 0, -1);
        mode_req = 3; frame(2, 2, 0, -1);
        frame(2, 2, 0, -1);
        frame(2, 2, 0, -1);

        // Mode request changes mid-frame, applies from next frame
        mode_req = 0; frame(1, 2, 1, -1);
        frame(3, 4, 1, 1);
        frame(2, 4, 1, -1);

        // Random frames
        repeat (12) begin
            mode_req = 2'($urandom_range(0, 3));
            frame($urandom_range(1, 4), $urandom_range(1, 9), 1,
                  ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : -1);
        end

        // Reset pulsed mid-line
        mode_req = 3;
        hs = 0; vs = 1; de = 0; step(); step();
        hs = 1; vs = 0; step();
        hs = 0; step();
        din_r = {CH{8'd180}};
        for (int p = 0; p < 3; p++) begin de = 1; randin(); din_r = {CH{8'd180}}; step(); end
        rst_pix = 1;
        #1;
        check_reset_outputs("rstmid");
        @(posedge clk_pix); #1;
        rst_pix = 0;
        reset_model();
        for (int p = 0; p < 4; p++) begin de = 1; step(); end
        de = 0; step();
        hs = 1; step();
        hs = 0; step();
        for (int p = 0; p < 4; p++) begin de = 1; step(); end
        de = 0; step();
        frame(2, 5, 1, -1);
        frame(2, 5, 1, -1);
        step(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
